// File: rtl/sched_pkg.sv
// Shared types and helpers for the memory port scheduler.
package sched_pkg;

    typedef enum logic {IDLE, BURST} state_t;

    localparam int unsigned CPU_ID = 0;

    // GPU pointer advance: index 0 belongs to the CPU, so wrap from the last GPU back to 1.
    function automatic int unsigned gpu_next_ptr(input int unsigned idx, input int unsigned num_req);
        return (idx >= num_req - 1) ? 1 : idx + 1;
    endfunction

endpackage

// File: rtl/gpu_rr_picker.sv
// Rotating-priority encoder over GPU requesters 1..N-1, starting at ptr.
module gpu_rr_picker
    import sched_pkg::*;
#(
    parameter int unsigned NUM_REQUESTERS = 9
) (
    input  logic [NUM_REQUESTERS-1:0]         req,
    input  logic [$clog2(NUM_REQUESTERS)-1:0] ptr,
    output logic                              found,
    output logic [$clog2(NUM_REQUESTERS)-1:0] idx
);

    localparam int unsigned IW = $clog2(NUM_REQUESTERS);

    int unsigned cand;

    always_comb begin
        found = 1'b0;
        idx   = '0;
        cand  = 0;
        for (int unsigned off = 0; off < NUM_REQUESTERS - 1; off++) begin
            // ptr is always in 1..N-1, so one conditional subtract keeps cand off index 0
            cand = 32'(ptr) + off;
            if (cand >= NUM_REQUESTERS) begin
                cand = cand - (NUM_REQUESTERS - 1);
            end
            if (!found && req[IW'(cand)]) begin
                found = 1'b1;
                idx   = IW'(cand);
            end
        end
    end

endmodule

// File: rtl/mem_port_scheduler.sv
// Burst-aware arbiter for one memory port: round-robin GPUs with priority, CPU as fallback.
// Optional CPU starvation guard enabled by defining SCHED_STARVE_EN.
module mem_port_scheduler
    import sched_pkg::*;
#(
    parameter int unsigned NUM_REQUESTERS = 9,
    parameter int unsigned MAX_BURST      = 16,
    parameter int unsigned STARVE_LIMIT   = 4
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NUM_REQUESTERS-1:0]         req_valid,
    input  logic [NUM_REQUESTERS-1:0]         req_last,
    output logic [NUM_REQUESTERS-1:0]         req_ready,
    output logic                              mem_valid,
    output logic                              mem_last,
    input  logic                              mem_ready,
    output logic [$clog2(NUM_REQUESTERS)-1:0] grant_id,
    output logic                              busy,
    output logic                              burst_err,
    output logic                              cpu_starve
);

    localparam int unsigned IW = $clog2(NUM_REQUESTERS);
    localparam int unsigned BW = $clog2(MAX_BURST + 1);

    if (NUM_REQUESTERS < 2 || MAX_BURST < 1 || STARVE_LIMIT < 1) begin : g_bad_params
        $error("mem_port_scheduler: illegal parameter values");
    end

    state_t         state, state_nxt;
    logic [IW-1:0]  owner, owner_nxt;
    logic [IW-1:0]  ptr, ptr_nxt;
    logic [BW-1:0]  beats, beats_nxt;
    logic           err_q, err_nxt;
    logic           pick_found;
    logic [IW-1:0]  pick_idx;
    logic           win_gpu;
    logic [IW-1:0]  win_idx;
    logic           any_req;
    logic           cpu_force;
    logic           xfer;

    gpu_rr_picker #(
        .NUM_REQUESTERS(NUM_REQUESTERS)
    ) u_picker (
        .req   (req_valid),
        .ptr   (ptr),
        .found (pick_found),
        .idx   (pick_idx)
    );

    assign any_req   = |req_valid;
    assign cpu_force = cpu_starve & req_valid[CPU_ID];
    assign win_gpu   = !cpu_force && pick_found;
    assign win_idx   = win_gpu ? pick_idx : IW'(CPU_ID);

    always_comb begin
        state_nxt = state;
        owner_nxt = owner;
        ptr_nxt   = ptr;
        beats_nxt = beats;
        err_nxt   = 1'b0;
        req_ready = '0;
        mem_valid = 1'b0;
        mem_last  = 1'b0;
        xfer      = 1'b0;
        case (state)
            IDLE: begin
                if (any_req) begin
                    state_nxt = BURST;
                    owner_nxt = win_idx;
                    if (win_gpu) begin
                        ptr_nxt = IW'(gpu_next_ptr(32'(win_idx), NUM_REQUESTERS));
                    end
                end
            end
            BURST: begin
                mem_valid        = req_valid[owner];
                mem_last         = req_last[owner];
                req_ready[owner] = mem_ready;
                xfer             = mem_valid && mem_ready;
                if (xfer) begin
                    if (mem_last) begin
                        state_nxt = IDLE;
                        beats_nxt = '0;
                    end else if (beats == BW'(MAX_BURST - 1)) begin
                        state_nxt = IDLE;
                        beats_nxt = '0;
                        err_nxt   = 1'b1;
                    end else begin
                        beats_nxt = beats + BW'(1);
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            owner <= '0;
            ptr   <= IW'(1);
            beats <= '0;
            err_q <= 1'b0;
        end else begin
            state <= state_nxt;
            owner <= owner_nxt;
            ptr   <= ptr_nxt;
            beats <= beats_nxt;
            err_q <= err_nxt;
        end
    end

`ifdef SCHED_STARVE_EN
    localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);

    logic [SW-1:0] starve_cnt;

    // Counts GPU wins the waiting CPU has lost in a row; any CPU win or CPU idle clears it.
    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt <= '0;
        end else if (state == IDLE) begin
            if (!req_valid[CPU_ID] || !win_gpu) begin
                starve_cnt <= '0;
            end else if (starve_cnt != SW'(STARVE_LIMIT)) begin
                starve_cnt <= starve_cnt + SW'(1);
            end
        end
    end

    assign cpu_starve = (starve_cnt == SW'(STARVE_LIMIT));
`else
    assign cpu_starve = 1'b0;
`endif

    assign busy      = (state == BURST);
    assign grant_id  = owner;
    assign burst_err = err_q;

endmodule

// File: tb/tb_mem_port_scheduler.sv
// Self-checking bench for mem_port_scheduler: transaction-level model plus directed scenarios.
module tb_mem_port_scheduler;

    localparam int N  = 9;
    localparam int MB = 16;
    localparam int SL = 4;
    localparam int IW = $clog2(N);

    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]  req_valid;
    logic [N-1:0]  req_last;
    logic [N-1:0]  req_ready;
    logic          mem_valid;
    logic          mem_last;
    logic          mem_ready;
    logic [IW-1:0] grant_id;
    logic          busy;
    logic          burst_err;
    logic          cpu_starve;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mem_port_scheduler #(
        .NUM_REQUESTERS(N),
        .MAX_BURST     (MB),
        .STARVE_LIMIT  (SL)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_last   (req_last),
        .req_ready  (req_ready),
        .mem_valid  (mem_valid),
        .mem_last   (mem_last),
        .mem_ready  (mem_ready),
        .grant_id   (grant_id),
        .busy       (busy),
        .burst_err  (burst_err),
        .cpu_starve (cpu_starve)
    );

    // Model: who owns the port, where the GPU rotation resumes, beats moved so far.
    bit m_busy;
    int m_owner;
    int m_ptr;
    int m_beats;
    bit m_err;
`ifdef SCHED_STARVE_EN
    int m_starve;
`endif

    // Monitor records
    bit           chk_en = 1'b0;
    bit           prev_busy;
    int           grants[$];
    int           exp_q[$];
    int           xfers;
    int           err_pulses;
    logic [N-1:0] rdy_or;
    bit           starve_seen;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    function automatic int model_winner(input logic [N-1:0] rv);
`ifdef SCHED_STARVE_EN
        if (m_starve == SL && rv[0]) return 0;
`endif
        for (int g = m_ptr; g < N; g++) if (rv[g]) return g;
        for (int g = 1; g < m_ptr; g++) if (rv[g]) return g;
        return 0;
    endfunction

    task automatic model_reset();
        m_busy  = 1'b0;
        m_owner = 0;
        m_ptr   = 1;
        m_beats = 0;
        m_err   = 1'b0;
`ifdef SCHED_STARVE_EN
        m_starve = 0;
`endif
    endtask

    task automatic model_step();
        int w;
        w = 0;
        if (rst) begin
            model_reset();
            return;
        end
        m_err = 1'b0;
        if (!m_busy) begin
            if (req_valid != '0) begin
                w       = model_winner(req_valid);
                m_busy  = 1'b1;
                m_owner = w;
                if (w != 0) m_ptr = (w == N - 1) ? 1 : w + 1;
            end
`ifdef SCHED_STARVE_EN
            if (req_valid[0] && w != 0) m_starve = (m_starve < SL) ? m_starve + 1 : SL;
            else                        m_starve = 0;
`endif
        end else if (req_valid[m_owner] && mem_ready) begin
            m_beats++;
            if (req_last[m_owner]) begin
                m_busy  = 1'b0;
                m_beats = 0;
            end else if (m_beats == MB) begin
                m_busy  = 1'b0;
                m_beats = 0;
                m_err   = 1'b1;
            end
        end
    endtask

    initial model_reset();

    // Compare DUT against the model every cycle, then advance the model with this cycle's inputs.
    always @(negedge clk) begin
        if (chk_en) begin
            if (busy && !prev_busy) grants.push_back(int'(grant_id));
            prev_busy = busy;
            if (mem_valid && mem_ready) xfers++;
            if (burst_err) err_pulses++;
            rdy_or = rdy_or | req_ready;
            if (cpu_starve) starve_seen = 1'b1;

            chk("busy", 32'(busy), 32'(m_busy));
            chk("req_ready", 32'(req_ready), 32'(m_busy ? (N'(mem_ready) << m_owner) : N'(0)));
            chk("mem_valid", 32'(mem_valid), 32'(m_busy ? req_valid[m_owner] : 1'b0));
            if (m_busy) begin
                chk("grant_id", 32'(grant_id), 32'(m_owner));
                chk("mem_last", 32'(mem_last), 32'(req_last[m_owner]));
            end
            chk("burst_err", 32'(burst_err), 32'(m_err));
`ifdef SCHED_STARVE_EN
            chk("cpu_starve", 32'(cpu_starve), 32'(m_starve == SL));
`else
            chk("cpu_starve", 32'(cpu_starve), 32'(0));
`endif
            model_step();
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        grants.delete();
        xfers       = 0;
        err_pulses  = 0;
        rdy_or      = '0;
        starve_seen = 1'b0;
    endtask

    task automatic chk_grants(input string name);
        chk($sformatf("%s_count", name), 32'(grants.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < grants.size(); i++) begin
            chk($sformatf("%s_%0d", name, i), 32'(grants[i]), 32'(exp_q[i]));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach the end of the test");
        $fatal(1);
    end

    initial begin
        rst       = 1'b1;
        req_valid = '0;
        req_last  = '0;
        mem_ready = 1'b0;
        prev_busy = 1'b0;
        clear_mon();
        repeat (2) cyc();
        chk_en = 1'b1;
        rst    = 1'b0;

        // Reset state
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_grant_id", 32'(grant_id), 32'(0));
        chk("rst_req_ready", 32'(req_ready), 32'(0));
        chk("rst_mem_valid", 32'(mem_valid), 32'(0));
        chk("rst_burst_err", 32'(burst_err), 32'(0));

        // Round-robin between GPUs 1 and 2 with single-beat bursts
        clear_mon();
        req_last  = '1;
        mem_ready = 1'b1;
        req_valid = 9'h006;
        repeat (8) cyc();
        req_valid = '0;
        exp_q = '{1, 2, 1, 2};
        chk_grants("rr_order");
        chk("rr_idle_after", 32'(busy), 32'(0));

        // Pointer wraps past N-1 to GPU 1, never to the CPU
        clear_mon();
        req_valid = 9'h100;
        repeat (2) cyc();
        req_valid = 9'h1FE;
        repeat (2) cyc();
        req_valid = '0;
        exp_q = '{8, 1};
        chk_grants("wrap");

        // Owner 3: four beats under mem_ready 1,0,1,1,1
        clear_mon();
        req_last  = '0;
        mem_ready = 1'b1;
        req_valid = 9'h008;
        cyc();
        cyc();
        mem_ready = 1'b0;
        cyc();
        mem_ready = 1'b1;
        cyc();
        cyc();
        req_last = 9'h008;
        cyc();
        req_valid = '0;
        req_last  = '0;
        chk("b4_xfers", 32'(xfers), 32'(4));
        chk("b4_ready_mask", 32'(rdy_or), 32'(9'h008));
        chk("b4_idle_after", 32'(busy), 32'(0));
        exp_q = '{3};
        chk_grants("b4_owner");

        // Owner 5: 16 non-last beats forces a release
        clear_mon();
        req_valid = 9'h020;
        repeat (17) cyc();
        chk("force_err_pulse", 32'(burst_err), 32'(1));
        chk("force_idle", 32'(busy), 32'(0));
        req_valid = '0;
        cyc();
        chk("force_err_clear", 32'(burst_err), 32'(0));
        chk("force_xfers", 32'(xfers), 32'(16));
        chk("force_pulses", 32'(err_pulses), 32'(1));
        exp_q = '{5};
        chk_grants("force_owner");

        // Owner 6: last on beat 16 is a normal release
        clear_mon();
        req_valid = 9'h040;
        repeat (16) cyc();
        req_last = 9'h040;
        cyc();
        req_valid = '0;
        req_last  = '0;
        cyc();
        chk("last16_xfers", 32'(xfers), 32'(16));
        chk("last16_pulses", 32'(err_pulses), 32'(0));

        // CPU against a persistent GPU 1
        clear_mon();
        req_last  = '1;
        req_valid = 9'h003;
        repeat (10) cyc();
        req_valid = '0;
`ifdef SCHED_STARVE_EN
        exp_q = '{1, 1, 1, 1, 0};
        chk("starve_seen", 32'(starve_seen), 32'(1));
`else
        exp_q = '{1, 1, 1, 1, 1};
        chk("starve_seen", 32'(starve_seen), 32'(0));
`endif
        chk_grants("starve");
        chk("starve_cleared", 32'(cpu_starve), 32'(0));

        // Reset during beat 2 of a 4-beat burst
        clear_mon();
        req_last  = '0;
        req_valid = 9'h010;
        cyc();
        cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk("mrst_busy", 32'(busy), 32'(0));
        chk("mrst_req_ready", 32'(req_ready), 32'(0));
        chk("mrst_grant_id", 32'(grant_id), 32'(0));
        chk("mrst_burst_err", 32'(burst_err), 32'(0));
        req_valid = 9'h1FE;
        req_last  = '1;
        repeat (2) cyc();
        req_valid = '0;
        cyc();
        exp_q = '{4, 1};
        chk_grants("mrst");
        chk("mrst_pulses", 32'(err_pulses), 32'(0));

        repeat (2) cyc();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
